// File: rtl/i2c_target_pkg.sv
// Shared types and bus constants for the I2C target responder.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one history flop; emits 1-cycle edge and START/STOP pulses.
module i2c_bus_sync
    import i2c_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic areset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic                   scl_cur, sda_cur;

    assign scl_cur = scl_sync_q[SYNC_STAGES-1];
    assign sda_cur = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_hist_d = scl_cur;
        sda_hist_d = sda_cur;
    end

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign sda_lvl   = sda_cur;
    assign scl_rise  = scl_cur & ~scl_hist_q;
    assign scl_fall  = ~scl_cur & scl_hist_q;
    assign start_det = scl_cur & scl_hist_q & sda_hist_q & ~sda_cur;
    assign stop_det  = scl_cur & scl_hist_q & ~sda_hist_q & sda_cur;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match, pointer byte, write/read of an internal byte register file.
module i2c_target_responder
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        IDX_W       = $clog2(NUM_REGS)
) (
    input  logic             pclk,
    input  logic             areset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_oen,
    output logic             scl_o,
    output logic             scl_oen,
    input  logic [IDX_W-1:0] host_addr,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [IDX_W-1:0] wr_idx,
    output logic [7:0]       wr_byte,
    output logic             busy
);

    logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .pclk     (pclk),
        .areset   (areset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_lvl  (sda_lvl),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             sda_oen_q, sda_oen_d;
    logic             busy_q, busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]       wr_byte_q, wr_byte_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];

    logic [7:0]       shift_in;
    logic [7:0]       ptr_byte;
    logic [IDX_W-1:0] ptr_inc;
    logic             byte_done;
    logic             addr_match;

    assign shift_in   = {shift_q[6:0], sda_lvl};
    assign ptr_byte   = regs_q[ptr_q];
    assign ptr_inc    = ptr_q + IDX_W'(1);
    assign byte_done  = (bit_cnt_q == BITS_PER_BYTE);
    assign addr_match = (shift_q[7:1] == TARGET_ADDR) && (TARGET_ADDR != 7'h00);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oen_d   = sda_oen_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_byte_d   = wr_byte_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            sda_oen_d = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            sda_oen_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && !byte_done) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        if (addr_match) begin
                            state_d   = ST_ADDR_ACK;
                            sda_oen_d = 1'b1;
                            rw_d      = shift_q[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q == RW_READ) begin
                            state_d   = ST_RDATA;
                            shift_d   = ptr_byte;
                            sda_oen_d = ~ptr_byte[7];
                        end else begin
                            state_d   = ST_PTR;
                            sda_oen_d = 1'b0;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise && !byte_done) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        ptr_d     = shift_q[IDX_W-1:0];
                        sda_oen_d = 1'b1;
                        state_d   = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oen_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && !byte_done) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit only once the last bit is in, so aborted bytes never land.
                        if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            wr_strobe_d = 1'b1;
                            wr_idx_d    = ptr_q;
                            wr_byte_d   = shift_in;
                            ptr_d       = ptr_inc;
                        end
                    end else if (scl_fall && byte_done) begin
                        sda_oen_d = 1'b1;
                        state_d   = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && !byte_done) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        sda_oen_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oen_d = ~shift_q[6];
                    end
                end
                ST_RDATA_ACK: begin
                    // bit_cnt marks that the master ACKed and the next byte is due.
                    if (scl_rise) begin
                        if (sda_lvl == ACK) begin
                            ptr_d     = ptr_inc;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        shift_d   = ptr_byte;
                        sda_oen_d = ~ptr_byte[7];
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                    end
                end
                default: begin
                    sda_oen_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= RW_WRITE;
            ptr_q       <= '0;
            sda_oen_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oen_q   <= sda_oen_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_idx_q    <= wr_idx_d;
            wr_byte_q   <= wr_byte_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_strobe_q) begin
            regs_d[wr_idx_q] = wr_byte_q;
        end
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign sda_o      = 1'b0;
    assign sda_oen    = sda_oen_q;
    assign scl_o      = 1'b0;
    assign scl_oen    = 1'b0;
    assign host_rdata = regs_q[host_addr];
    assign wr_strobe  = wr_strobe_q;
    assign wr_idx     = wr_idx_q;
    assign wr_byte    = wr_byte_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bus-level bench: bit-banged I2C master against a register-file reference model.
module tb_i2c_target_responder;

    localparam int NREG = 16;
    localparam int Q    = 6;

    logic       pclk = 1'b0;
    logic       areset;
    logic       scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_o, sda_oen, scl_o, scl_oen;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_idx;
    logic [7:0] wr_byte;
    logic       busy;

    assign sda_bus = m_sda & ~sda_oen;

    always #5 pclk = ~pclk;

    i2c_target_responder dut (
        .pclk      (pclk),
        .areset    (areset),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_oen   (sda_oen),
        .scl_o     (scl_o),
        .scl_oen   (scl_oen),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_strobe (wr_strobe),
        .wr_idx    (wr_idx),
        .wr_byte   (wr_byte),
        .busy      (busy)
    );

    int          tests = 0;
    int          fails = 0;
    logic [11:0] strobe_log [1024];
    int          strobe_cnt = 0;
    int          oen_cnt = 0;

    logic [7:0]  mregs [NREG];
    int          mptr;
    logic [7:0]  wq [$];

    always @(negedge pclk) begin
        if (wr_strobe && strobe_cnt < 1024) begin
            strobe_log[strobe_cnt] = {wr_idx, wr_byte};
            strobe_cnt = strobe_cnt + 1;
        end
        if (sda_oen) oen_cnt = oen_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input int idx, input logic [7:0] exp);
        host_addr = 4'(idx);
        #1;
        check("host_rdata", {24'h0, host_rdata}, {24'h0, exp});
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic wbit(input logic b);
        m_sda = b; tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        b = sda_bus; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic mack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            rbit(bit_v);
            b[i] = bit_v;
        end
        wbit(mack);
    endtask

    // Writes pointer p then every byte queued in wq; model applies the same bytes.
    task automatic write_txn(input logic [7:0] p);
        logic        ack;
        int          base;
        logic [11:0] exp_q [$];
        base = strobe_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check("w_addr_ack", 32'(ack), 32'(0));
        send_byte(p, ack);     check("w_ptr_ack", 32'(ack), 32'(0));
        mptr = int'(p) % NREG;
        foreach (wq[k]) begin
            send_byte(wq[k], ack);
            check("w_data_ack", 32'(ack), 32'(0));
            mregs[mptr] = wq[k];
            exp_q.push_back({4'(mptr), wq[k]});
            mptr = (mptr + 1) % NREG;
        end
        i2c_stop();
        check("w_busy_end", 32'(busy), 32'(0));
        check("w_strobe_cnt", 32'(strobe_cnt - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < strobe_cnt; k++)
            check("w_strobe_log", 32'(strobe_log[base + k]), 32'(exp_q[k]));
        foreach (exp_q[k]) check_reg(int'(exp_q[k][11:8]), mregs[exp_q[k][11:8]]);
    endtask

    // Sets pointer p, repeated START, reads n bytes (ACK all but the last).
    task automatic read_txn(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        logic       mack;
        i2c_start();
        send_byte(8'hA0, ack); check("r_addr_ack", 32'(ack), 32'(0));
        send_byte(p, ack);     check("r_ptr_ack", 32'(ack), 32'(0));
        mptr = int'(p) % NREG;
        i2c_start();
        send_byte(8'hA1, ack); check("r_raddr_ack", 32'(ack), 32'(0));
        for (int k = 0; k < n; k++) begin
            mack = (k == n - 1);
            recv_byte(d, mack);
            check("r_data", 32'(d), 32'(mregs[mptr]));
            if (!mack) mptr = (mptr + 1) % NREG;
        end
        tick(Q);
        check("r_release", 32'(sda_oen), 32'(0));
        i2c_stop();
        check("r_busy_end", 32'(busy), 32'(0));
    endtask

    // Foreign address: two bytes, both NACKed, nothing driven or written.
    task automatic foreign_txn(input logic [7:0] a, input logic [7:0] b);
        logic ack;
        int   base_s, base_o;
        base_s = strobe_cnt;
        base_o = oen_cnt;
        i2c_start();
        send_byte(a, ack); check("x_addr_nack", 32'(ack), 32'(1));
        check("x_busy_mid", 32'(busy), 32'(1));
        send_byte(b, ack); check("x_data_nack", 32'(ack), 32'(1));
        i2c_stop();
        check("x_busy_end", 32'(busy), 32'(0));
        check("x_no_oen", 32'(oen_cnt - base_o), 32'(0));
        check("x_no_strobe", 32'(strobe_cnt - base_s), 32'(0));
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] p;
        int         base_s;
        int         n;
        logic [6:0] a7;

        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        areset = 1'b1; scl = 1'b1; m_sda = 1'b1; host_addr = 4'd0;
        tick(5);
        check("rst_sda_oen", 32'(sda_oen), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wr_strobe", 32'(wr_strobe), 32'(0));
        check("rst_consts", {28'h0, sda_o, scl_o, scl_oen, 1'b0}, 32'h0);
        areset = 1'b0;
        tick(5);
        check_reg(7, 8'h00);

        wq = '{8'h5A, 8'hC3};
        write_txn(8'h03);
        check_reg(4, 8'hC3);
        check_reg(3, 8'h5A);

        read_txn(8'h03, 2);

        foreign_txn(8'hA2, 8'h11);

        wq = '{8'h11, 8'h22};
        write_txn(8'h0F);
        check_reg(15, 8'h11);
        check_reg(0, 8'h22);

        // Abort a data byte after five bits, then read from the unchanged pointer.
        p = 8'($urandom_range(0, 255));
        base_s = strobe_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check("a_addr_ack", 32'(ack), 32'(0));
        send_byte(p, ack);     check("a_ptr_ack", 32'(ack), 32'(0));
        for (int i = 0; i < 5; i++) wbit(1'($urandom));
        i2c_stop();
        check("a_no_strobe", 32'(strobe_cnt - base_s), 32'(0));
        i2c_start();
        send_byte(8'hA1, ack); check("a_raddr_ack", 32'(ack), 32'(0));
        recv_byte(d, 1'b1);
        check("a_read_ptr", 32'(d), 32'(mregs[int'(p) % NREG]));
        i2c_stop();

        for (int it = 0; it < 22; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    wq.delete();
                    n = $urandom_range(1, 4);
                    repeat (n) wq.push_back(8'($urandom));
                    write_txn(8'($urandom));
                end
                2: read_txn(8'($urandom), $urandom_range(1, 3));
                default: begin
                    a7 = 7'($urandom_range(0, 127));
                    if (a7 == 7'h50) a7 = 7'h00;
                    foreign_txn({a7, 1'($urandom)}, 8'($urandom));
                end
            endcase
        end

        // Reset while the target holds the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(1'(8'hA0 >> i));
        m_sda = 1'b1;
        tick(Q);
        check("ack_driven", 32'(sda_oen), 32'(1));
        areset = 1'b1;
        #1;
        check("rst_release_now", 32'(sda_oen), 32'(0));
        scl = 1'b1; m_sda = 1'b1;
        tick(4);
        areset = 1'b0;
        tick(4);
        check("post_rst_busy", 32'(busy), 32'(0));
        for (int i = 0; i < NREG; i++) check_reg(i, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
